// File: rtl/dds_pkg.sv
// dds_pkg: shared definitions for the DDS phase sequencer.
//   - `ROM_PHASE_BIT / `ROM_PHASE_MAX_VAL: waveform ROM address width and
//     largest address. Global defines, given defaults here if not already set.
//   - wave_e: waveform codes that select one of the ROM outputs.
//   - state_e: sequencer state encoding.
//   - DEF_ACC_W / DEF_CNT_W: default accumulator and burst-counter widths.
// Optional feature macro used by the files that import this package:
//   DDS_PHASE_OFFSET_EN
`ifndef ROM_PHASE_BIT
`define ROM_PHASE_BIT 10
`endif
`ifndef ROM_PHASE_MAX_VAL
`define ROM_PHASE_MAX_VAL ((1 << `ROM_PHASE_BIT) - 1)
`endif

package dds_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE     = 2'd0,
    WAVE_SQUARE   = 2'd1,
    WAVE_TRIANGLE = 2'd2,
    WAVE_SAW      = 2'd3
  } wave_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam int DEF_ACC_W = 32;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/dds_cfg_shadow.sv
// dds_cfg_shadow: single-entry shadow register for DDS configuration words.
// A word is taken when cfg_valid && cfg_ready. cfg_ready is low while the
// shadow holds a word. The owner consumes the word by pulsing apply, which
// empties the shadow on the same edge. Because loading needs the shadow
// empty and apply is only meaningful when it is full, they never coincide.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cfg_valid/cfg_ready   config handshake
//   cfg_ftw/wave/cycles   incoming config fields
//   cfg_off / sh_off      phase offset field (only with DDS_PHASE_OFFSET_EN)
//   apply                 consume the shadow contents
//   full                  shadow holds an unconsumed word
//   sh_ftw/wave/cycles    shadow contents
module dds_cfg_shadow
  import dds_pkg::*;
#(
  parameter int ACC_W   = DEF_ACC_W,
`ifdef DDS_PHASE_OFFSET_EN
  parameter int PHASE_W = `ROM_PHASE_BIT,
`endif
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [ACC_W-1:0]   cfg_ftw,
  input  logic [1:0]         cfg_wave,
  input  logic [CNT_W-1:0]   cfg_cycles,
`ifdef DDS_PHASE_OFFSET_EN
  input  logic [PHASE_W-1:0] cfg_off,
  output logic [PHASE_W-1:0] sh_off,
`endif
  input  logic               apply,
  output logic               full,
  output logic [ACC_W-1:0]   sh_ftw,
  output wave_e              sh_wave,
  output logic [CNT_W-1:0]   sh_cycles
);

  logic take;

  assign cfg_ready = ~full;
  assign take      = cfg_valid & ~full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full      <= 1'b0;
      sh_ftw    <= '0;
      sh_wave   <= WAVE_SINE;
      sh_cycles <= '0;
`ifdef DDS_PHASE_OFFSET_EN
      sh_off    <= '0;
`endif
    end else if (take) begin
      full      <= 1'b1;
      sh_ftw    <= cfg_ftw;
      sh_wave   <= wave_e'(cfg_wave);
      sh_cycles <= cfg_cycles;
`ifdef DDS_PHASE_OFFSET_EN
      sh_off    <= cfg_off;
`endif
    end else if (apply) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/dds_phase_ctrl.sv
// dds_phase_ctrl: phase-accumulator sequencer for the DDS waveform ROMs.
// New settings arrive through dds_cfg_shadow and become active either
// immediately while idle or at the next accumulator wrap while running, so
// the output phase never jumps mid-period. Runs continuously
// (cfg_cycles == 0) or for a fixed number of output periods; a graceful stop
// finishes the current period. A one-cycle DRAIN state covers the ROM read
// latency before done is pulsed.
// Optional feature (macro DDS_PHASE_OFFSET_EN): adds input phase_off, a
// phase offset captured together with the rest of the configuration.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cfg_valid/cfg_ready   config handshake
//   cfg_ftw               frequency tuning word
//   cfg_wave              waveform select (sine/square/triangle/saw)
//   cfg_cycles            burst length in periods, 0 = continuous
//   start, stop           single-cycle start / graceful stop requests
//   phase_off             phase offset (only with DDS_PHASE_OFFSET_EN)
//   phase                 ROM address
//   wave_sel              active waveform, ROM output mux select
//   value_valid           ROM value of this cycle is valid
//   busy                  sequencer not idle
//   done                  one-cycle pulse on return to idle
module dds_phase_ctrl
  import dds_pkg::*;
#(
  parameter int ACC_W   = DEF_ACC_W,
  parameter int PHASE_W = `ROM_PHASE_BIT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [ACC_W-1:0]   cfg_ftw,
  input  logic [1:0]         cfg_wave,
  input  logic [CNT_W-1:0]   cfg_cycles,
  input  logic               start,
  input  logic               stop,
`ifdef DDS_PHASE_OFFSET_EN
  input  logic [PHASE_W-1:0] phase_off,
`endif
  output logic [PHASE_W-1:0] phase,
  output logic [1:0]         wave_sel,
  output logic               value_valid,
  output logic               busy,
  output logic               done
);

  state_e             state_reg, state_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic [ACC_W-1:0]   ftw_reg;
  logic [CNT_W-1:0]   cnt_reg, cnt_next, cnt_inc;
  logic [CNT_W-1:0]   cycles_reg;
  wave_e              wave_reg;
  logic               stop_reg, stop_next;
  logic               vv_reg, done_reg;
  logic [ACC_W:0]     sum;
  logic               wrap;
  logic               apply;

  logic               sh_full;
  logic [ACC_W-1:0]   sh_ftw;
  wave_e              sh_wave;
  logic [CNT_W-1:0]   sh_cycles;
`ifdef DDS_PHASE_OFFSET_EN
  logic [PHASE_W-1:0] sh_off;
  logic [PHASE_W-1:0] off_reg;
`endif

  dds_cfg_shadow #(
    .ACC_W   (ACC_W),
`ifdef DDS_PHASE_OFFSET_EN
    .PHASE_W (PHASE_W),
`endif
    .CNT_W   (CNT_W)
  ) u_shadow (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ftw    (cfg_ftw),
    .cfg_wave   (cfg_wave),
    .cfg_cycles (cfg_cycles),
`ifdef DDS_PHASE_OFFSET_EN
    .cfg_off    (phase_off),
    .sh_off     (sh_off),
`endif
    .apply      (apply),
    .full       (sh_full),
    .sh_ftw     (sh_ftw),
    .sh_wave    (sh_wave),
    .sh_cycles  (sh_cycles)
  );

  // The carry out of the accumulator add marks the end of an output period.
  assign sum     = {1'b0, acc_reg} + {1'b0, ftw_reg};
  assign wrap    = (state_reg == S_RUN) && sum[ACC_W];
  assign cnt_inc = cnt_reg + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    stop_next  = stop_reg;
    apply      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        acc_next  = '0;
        stop_next = 1'b0;
        // A pending word goes live right away; with start on the same edge
        // the run begins with the new settings.
        apply     = sh_full;
        if (start) begin
          state_next = S_RUN;
          cnt_next   = '0;
        end
      end
      S_RUN: begin
        acc_next = sum[ACC_W-1:0];
        if (stop) stop_next = 1'b1;
        if (wrap) begin
          apply    = sh_full;
          cnt_next = cnt_inc;
          if (stop_reg || stop ||
              ((cycles_reg != '0) && (cnt_inc == cycles_reg)))
            state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        acc_next   = '0;
        stop_next  = 1'b0;
        state_next = S_IDLE;
      end
      default: begin
        acc_next   = '0;
        stop_next  = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg    <= '0;
      cnt_reg    <= '0;
      stop_reg   <= 1'b0;
      vv_reg     <= 1'b0;
      done_reg   <= 1'b0;
      ftw_reg    <= '0;
      wave_reg   <= WAVE_SINE;
      cycles_reg <= '0;
`ifdef DDS_PHASE_OFFSET_EN
      off_reg    <= '0;
`endif
    end else begin
      acc_reg  <= acc_next;
      cnt_reg  <= cnt_next;
      stop_reg <= stop_next;
      // ROM read latency is one cycle, so validity trails RUN by one cycle.
      vv_reg   <= (state_reg == S_RUN);
      done_reg <= (state_reg == S_DRAIN);
      if (apply) begin
        ftw_reg    <= sh_ftw;
        wave_reg   <= sh_wave;
        cycles_reg <= sh_cycles;
`ifdef DDS_PHASE_OFFSET_EN
        off_reg    <= sh_off;
`endif
      end
    end
  end

`ifdef DDS_PHASE_OFFSET_EN
  assign phase = acc_reg[ACC_W-1 -: PHASE_W] + off_reg;
`else
  assign phase = acc_reg[ACC_W-1 -: PHASE_W];
`endif
  assign wave_sel    = wave_reg;
  assign value_valid = vv_reg;
  assign busy        = (state_reg != S_IDLE);
  assign done        = done_reg;

endmodule

// File: tb/tb_dds_phase_ctrl.sv
// tb_dds_phase_ctrl: directed bench for dds_phase_ctrl (ACC_W=32,
// PHASE_W=10, CNT_W=16). A per-cycle vector table covers a 2-period burst,
// start during RUN and start+stop in IDLE; hand-written sequences cover
// reconfiguration at wrap, graceful stop, asynchronous reset and, when
// DDS_PHASE_OFFSET_EN is defined, the phase offset.
`timescale 1ns/1ps
module tb_dds_phase_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_ftw = '0;
  logic [1:0]  cfg_wave = '0;
  logic [15:0] cfg_cycles = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
`ifdef DDS_PHASE_OFFSET_EN
  logic [9:0]  phase_off = '0;
`endif
  logic [9:0]  phase;
  logic [1:0]  wave_sel;
  logic        value_valid;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dds_phase_ctrl #(.ACC_W(32), .PHASE_W(10), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ftw     (cfg_ftw),
    .cfg_wave    (cfg_wave),
    .cfg_cycles  (cfg_cycles),
    .start       (start),
    .stop        (stop),
`ifdef DDS_PHASE_OFFSET_EN
    .phase_off   (phase_off),
`endif
    .phase       (phase),
    .wave_sel    (wave_sel),
    .value_valid (value_valid),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    logic        cv;
    logic [31:0] ftw;
    logic [1:0]  wv;
    logic [15:0] cy;
    logic        st;
    logic        sp;
    logic [9:0]  ph;
    logic [1:0]  ws;
    logic        vv;
    logic        bs;
    logic        dn;
    logic        rdy;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(input logic cv, input logic [31:0] ftw,
                              input logic [1:0] wv, input logic [15:0] cy,
                              input logic st, input logic sp,
                              input logic [9:0] ph, input logic [1:0] ws,
                              input logic vv, input logic bs,
                              input logic dn, input logic rdy);
    vec_t v;
    v.cv = cv; v.ftw = ftw; v.wv = wv; v.cy = cy; v.st = st; v.sp = sp;
    v.ph = ph; v.ws = ws; v.vv = vv; v.bs = bs; v.dn = dn; v.rdy = rdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [31:0] f, input logic [1:0] w,
                         input logic [15:0] c);
    cfg_valid  = 1'b1;
    cfg_ftw    = f;
    cfg_wave   = w;
    cfg_cycles = c;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int vv_cnt;
    bit seen_done;

    // ftw = 2^30 advances phase by 256 per cycle; 2-period burst
    tbl[0]  = mk(1, 32'h4000_0000, 2'd1, 16'd2, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 32'h0,         2'd0, 16'd0, 1, 0,   0, 1, 0, 1, 0, 1);
    tbl[2]  = mk(0, 32'h0,         2'd0, 16'd0, 0, 0, 256, 1, 1, 1, 0, 1);
    tbl[3]  = mk(0, 32'h0,         2'd0, 16'd0, 0, 0, 512, 1, 1, 1, 0, 1);
    tbl[4]  = mk(0, 32'h0,         2'd0, 16'd0, 0, 0, 768, 1, 1, 1, 0, 1);
    tbl[5]  = mk(0, 32'h0,         2'd0, 16'd0, 0, 0,   0, 1, 1, 1, 0, 1);
    tbl[6]  = mk(0, 32'h0,         2'd0, 16'd0, 1, 0, 256, 1, 1, 1, 0, 1);
    tbl[7]  = mk(0, 32'h0,         2'd0, 16'd0, 0, 0, 512, 1, 1, 1, 0, 1);
    tbl[8]  = mk(0, 32'h0,         2'd0, 16'd0, 0, 0, 768, 1, 1, 1, 0, 1);
    tbl[9]  = mk(0, 32'h0,         2'd0, 16'd0, 0, 0,   0, 1, 1, 1, 0, 1);
    tbl[10] = mk(0, 32'h0,         2'd0, 16'd0, 0, 0,   0, 1, 0, 0, 1, 1);
    tbl[11] = mk(0, 32'h0,         2'd0, 16'd0, 0, 0,   0, 1, 0, 0, 0, 1);
    // start+stop together in IDLE: run must last the full burst again
    tbl[12] = mk(0, 32'h0,         2'd0, 16'd0, 1, 1,   0, 1, 0, 1, 0, 1);
    tbl[13] = mk(0, 32'h0,         2'd0, 16'd0, 0, 0, 256, 1, 1, 1, 0, 1);
    tbl[14] = mk(0, 32'h0,         2'd0, 16'd0, 0, 0, 512, 1, 1, 1, 0, 1);
    tbl[15] = mk(0, 32'h0,         2'd0, 16'd0, 0, 0, 768, 1, 1, 1, 0, 1);
    tbl[16] = mk(0, 32'h0,         2'd0, 16'd0, 0, 0,   0, 1, 1, 1, 0, 1);
    tbl[17] = mk(0, 32'h0,         2'd0, 16'd0, 0, 0, 256, 1, 1, 1, 0, 1);
    tbl[18] = mk(0, 32'h0,         2'd0, 16'd0, 0, 0, 512, 1, 1, 1, 0, 1);
    tbl[19] = mk(0, 32'h0,         2'd0, 16'd0, 0, 0, 768, 1, 1, 1, 0, 1);
    tbl[20] = mk(0, 32'h0,         2'd0, 16'd0, 0, 0,   0, 1, 1, 1, 0, 1);
    tbl[21] = mk(0, 32'h0,         2'd0, 16'd0, 0, 0,   0, 1, 0, 0, 1, 1);

    // Reset state
    step();
    step();
    rst = 1'b0;
    chk("reset.phase", phase, 0);
    chk("reset.wave_sel", wave_sel, 0);
    chk("reset.value_valid", value_valid, 0);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.cfg_ready", cfg_ready, 1);

    // Table-driven burst / start-ignore / start+stop
    for (int i = 0; i < 22; i++) begin
      cfg_valid  = tbl[i].cv;
      cfg_ftw    = tbl[i].ftw;
      cfg_wave   = tbl[i].wv;
      cfg_cycles = tbl[i].cy;
      start      = tbl[i].st;
      stop       = tbl[i].sp;
      step();
      $display("vec %0d: phase=%0d wave_sel=%0d vv=%0b busy=%0b done=%0b rdy=%0b",
               i, phase, wave_sel, value_valid, busy, done, cfg_ready);
      chk($sformatf("v%0d.phase", i), phase, tbl[i].ph);
      chk($sformatf("v%0d.wave_sel", i), wave_sel, tbl[i].ws);
      chk($sformatf("v%0d.value_valid", i), value_valid, tbl[i].vv);
      chk($sformatf("v%0d.busy", i), busy, tbl[i].bs);
      chk($sformatf("v%0d.done", i), done, tbl[i].dn);
      chk($sformatf("v%0d.cfg_ready", i), cfg_ready, tbl[i].rdy);
    end
    cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;

    // A: continuous run at 2^28 (64/step), reconfigure mid-period
    set_cfg(32'h1000_0000, 2'd0, 16'd0);
    step();
    cfg_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    chk("A.phase_mid", phase, 448);
    set_cfg(32'h2000_0000, 2'd2, 16'd0);
    step();
    cfg_valid = 1'b0;
    chk("A.ready_low", cfg_ready, 0);
    chk("A.phase_8", phase, 512);
    repeat (7) step();
    chk("A.phase_15", phase, 960);
    chk("A.wave_before_wrap", wave_sel, 0);
    chk("A.ready_before_wrap", cfg_ready, 0);
    step();
    chk("A.phase_wrap", phase, 0);
    chk("A.wave_at_wrap", wave_sel, 2);
    chk("A.ready_after_copy", cfg_ready, 1);
    step();
    chk("A.new_step", phase, 128);
    $display("seq A: reconfigure at wrap, phase=%0d wave_sel=%0d", phase, wave_sel);
    // graceful stop at acc=2^29: finishes the period (7 more edges)
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (5) step();
    chk("A.stop_phase", phase, 896);
    chk("A.stop_busy", busy, 1);
    step();
    chk("A.drain_busy", busy, 1);
    chk("A.drain_vv", value_valid, 1);
    step();
    chk("A.stop_done", done, 1);
    chk("A.stop_idle", busy, 0);
    $display("seq A: stop completed, done=%0b busy=%0b", done, busy);

    // B: stop at acc=0x5000_0000 with ftw=2^28 -> one full period of valid
    set_cfg(32'h1000_0000, 2'd3, 16'd0);
    step();
    cfg_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    vv_cnt = 0;
    repeat (5) begin
      step();
      if (value_valid) vv_cnt++;
    end
    chk("B.phase_at_stop", phase, 320);
    stop = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      step();
      stop = 1'b0;
      if (value_valid) vv_cnt++;
      if (done) seen_done = 1'b1;
    end
    chk("B.done_seen", seen_done, 1);
    chk("B.valid_count", vv_cnt, 16);
    chk("B.wave_sel", wave_sel, 3);
    $display("seq B: stop mid-period, valid cycles=%0d", vv_cnt);

    // C: async reset mid-RUN with a pending shadow word
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    set_cfg(32'h4000_0000, 2'd1, 16'd0);
    step();
    cfg_valid = 1'b0;
    chk("C.ready_pending", cfg_ready, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("C.rst_phase", phase, 0);
    chk("C.rst_wave", wave_sel, 0);
    chk("C.rst_vv", value_valid, 0);
    chk("C.rst_busy", busy, 0);
    chk("C.rst_done", done, 0);
    chk("C.rst_ready", cfg_ready, 1);
    step();
    rst = 1'b0;
    // with the shadow dropped, active ftw is 0: acc stays frozen at 0
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("C.after_phase", phase, 0);
    chk("C.after_wave", wave_sel, 0);
    chk("C.after_busy", busy, 1);
    $display("seq C: async reset, phase=%0d wave_sel=%0d busy=%0b", phase, wave_sel, busy);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

`ifdef DDS_PHASE_OFFSET_EN
    // D: phase offset 512 captured with the config word
    phase_off = 10'd512;
    set_cfg(32'h4000_0000, 2'd0, 16'd0);
    step();
    cfg_valid = 1'b0;
    phase_off = 10'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("D.phase0", phase, 512);
    step();
    chk("D.phase1", phase, 768);
    step();
    chk("D.phase2", phase, 0);
    step();
    chk("D.phase3", phase, 256);
    $display("seq D: phase offset, phase=%0d", phase);
    rst = 1'b1;
    step();
    rst = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
